// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives PC load controls, issues in-order memory requests under
// credit gating, tags responses with their fetch address and buffers them for decode.
module fetch_unit #(
    parameter int WIDTH_P      = 32,
    parameter int FIFO_DEPTH_P = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [WIDTH_P-1:0] pc_q_i,
    output logic               pc_load_o,
    output logic [WIDTH_P-1:0] pc_load_val_o,
    input  logic               redirect_i,
    input  logic [WIDTH_P-1:0] redirect_pc_i,
    output logic               imem_req_o,
    output logic [WIDTH_P-1:0] imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [31:0]        imem_rdata_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [31:0]        instr_o,
    output logic [WIDTH_P-1:0] instr_pc_o
);
    localparam int AW = $clog2(FIFO_DEPTH_P);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH_P);

    // outstanding_q counts every request in flight, including those marked for discard
    logic [CW-1:0]      outstanding_q;
    logic [CW-1:0]      discard_q;
    logic [CW-1:0]      fifo_cnt_q;
    logic [AW-1:0]      pend_wr_q;
    logic [AW-1:0]      pend_rd_q;
    logic [AW-1:0]      fifo_wr_q;
    logic [AW-1:0]      fifo_rd_q;
    logic [WIDTH_P-1:0] pend_addr_q  [FIFO_DEPTH_P];
    logic [WIDTH_P-1:0] fifo_pc_q    [FIFO_DEPTH_P];
    logic [31:0]        fifo_instr_q [FIFO_DEPTH_P];

    logic          redirect;
    logic          issue;
    logic          drop;
    logic          accept;
    logic          pop;
    logic [CW-1:0] credits;

    assign redirect      = redirect_i && rst_n_i;
    assign instr_valid_o = (fifo_cnt_q != '0);
    assign pop           = instr_valid_o && instr_ready_i && !redirect;

    // An entry leaving the buffer this cycle frees its credit immediately, so a
    // two-entry buffer sustains one instruction per cycle at single-cycle latency.
    assign credits    = outstanding_q + fifo_cnt_q - CW'(pop);
    assign imem_req_o = rst_n_i && !redirect && (credits < DEPTH_C);
    assign imem_addr_o = pc_q_i;
    assign issue      = imem_req_o && imem_gnt_i;

    assign drop   = imem_rvalid_i && (redirect || (discard_q != '0));
    assign accept = imem_rvalid_i && !drop;

    assign pc_load_o     = !issue;
    assign pc_load_val_o = redirect ? (redirect_pc_i & ~WIDTH_P'(3)) : pc_q_i;

    assign instr_o    = fifo_instr_q[fifo_rd_q];
    assign instr_pc_o = fifo_pc_q[fifo_rd_q];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            outstanding_q <= '0;
            discard_q     <= '0;
            fifo_cnt_q    <= '0;
            pend_wr_q     <= '0;
            pend_rd_q     <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH_P; i++) begin
                pend_addr_q[i]  <= '0;
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            outstanding_q <= outstanding_q + CW'(issue) - CW'(imem_rvalid_i);
            if (redirect) begin
                // everything still in flight is stale, including a response arriving now
                discard_q  <= outstanding_q - CW'(imem_rvalid_i);
                fifo_cnt_q <= '0;
                pend_wr_q  <= '0;
                pend_rd_q  <= '0;
                fifo_wr_q  <= '0;
                fifo_rd_q  <= '0;
            end else begin
                if (drop) begin
                    discard_q <= discard_q - 1'b1;
                end
                if (issue) begin
                    pend_addr_q[pend_wr_q] <= pc_q_i;
                    pend_wr_q              <= pend_wr_q + 1'b1;
                end
                if (accept) begin
                    fifo_pc_q[fifo_wr_q]    <= pend_addr_q[pend_rd_q];
                    fifo_instr_q[fifo_wr_q] <= imem_rdata_i;
                    fifo_wr_q               <= fifo_wr_q + 1'b1;
                    pend_rd_q               <= pend_rd_q + 1'b1;
                end
                if (pop) begin
                    fifo_rd_q <= fifo_rd_q + 1'b1;
                end
                fifo_cnt_q <= fifo_cnt_q + CW'(accept) - CW'(pop);
            end
        end
    end

    no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(accept && (fifo_cnt_q == DEPTH_C)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural PC register and an in-order
// instruction memory of configurable response latency.
module tb_fetch_unit;
    localparam int W = 32;
    localparam int D = 2;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] pc_q;
    logic         pc_load;
    logic [W-1:0] pc_load_val;
    logic         redirect;
    logic [W-1:0] redirect_pc;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    logic         instr_valid;
    logic         instr_ready;
    logic [31:0]  instr;
    logic [W-1:0] instr_pc;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;

    fetch_unit #(.WIDTH_P(W), .FIFO_DEPTH_P(D)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .pc_q_i        (pc_q),
        .pc_load_o     (pc_load),
        .pc_load_val_o (pc_load_val),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pc_q <= '0;
        else if (pc_load) pc_q <= pc_load_val;
        else              pc_q <= pc_q + 32'd4;
    end

    function automatic logic [31:0] mem_word(input logic [W-1:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // memory: sampled mid-cycle, so inputs set just after a rising edge are seen
    logic [W-1:0] q_addr[$];
    int           q_due[$];
    int           last_due;
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        last_due    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q_addr.delete();
                q_due.delete();
                imem_rvalid = 1'b0;
                last_due    = 0;
            end else begin
                if (q_due.size() > 0 && q_due[0] <= cyc) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(q_addr[0]);
                    void'(q_addr.pop_front());
                    void'(q_due.pop_front());
                end else begin
                    imem_rvalid = 1'b0;
                end
                if (imem_req && imem_gnt) begin
                    last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                    q_addr.push_back(imem_addr);
                    q_due.push_back(last_due);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // leaves the bench one tick after the release edge: cycle 0 of the new run
    task automatic apply_reset;
        rst_n    = 1'b0;
        redirect = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; instr_ready = 1'b1; imem_gnt = 1'b1;
        redirect = 1'b0; redirect_pc = '0; lat = 1;
        tick;
        tick;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instr); end
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
        checks++; if (pc_load !== 1'b1) begin failures++; $display("FAIL rst_pc_load got=%b exp=1", pc_load); end
        checks++; if (pc_load_val !== 32'h0) begin failures++; $display("FAIL rst_pc_load_val got=%h exp=0", pc_load_val); end
    endtask

    task automatic test_stream;
        instr_ready = 1'b1; imem_gnt = 1'b1; lat = 1;
        apply_reset;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k) || pc_load !== 1'b0) begin
                failures++;
                $display("FAIL stream_req k=%0d got req=%b addr=%h load=%b exp req=1 addr=%h load=0",
                         k, imem_req, imem_addr, pc_load, 32'(4 * k));
            end
            if (k >= 2) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (k - 2)) || instr !== mem_word(32'(4 * (k - 2)))) begin
                    failures++;
                    $display("FAIL stream_instr k=%0d got v=%b pc=%h i=%h exp v=1 pc=%h i=%h", k, instr_valid,
                             instr_pc, instr, 32'(4 * (k - 2)), mem_word(32'(4 * (k - 2))));
                end
            end else begin
                checks++;
                if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid k=%0d got=%b exp=0", k, instr_valid); end
            end
            tick;
        end
    endtask

    task automatic test_decode_stall;
        int nreq;
        instr_ready = 1'b0; imem_gnt = 1'b1; lat = 1;
        apply_reset;
        nreq = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (imem_req && imem_gnt) nreq++;
            tick;
        end
        #1;
        checks++; if (nreq !== D) begin failures++; $display("FAIL stall_nreq got=%0d exp=%0d", nreq, D); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req got=%b exp=0", imem_req); end
        checks++; if (pc_load !== 1'b1 || pc_load_val !== 32'h8) begin failures++; $display("FAIL stall_hold got load=%b val=%h exp load=1 val=8", pc_load, pc_load_val); end
        checks++; if (pc_q !== 32'h8) begin failures++; $display("FAIL stall_pc got=%h exp=8", pc_q); end
        instr_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * j) || instr !== mem_word(32'(4 * j))) begin
                failures++;
                $display("FAIL stall_drain j=%0d got v=%b pc=%h i=%h exp v=1 pc=%h", j, instr_valid, instr_pc, instr, 32'(4 * j));
            end
            tick;
        end
    endtask

    task automatic test_gnt_stall;
        instr_ready = 1'b1; imem_gnt = 1'b0; lat = 1;
        apply_reset;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (imem_req !== 1'b1 || pc_load !== 1'b1 || pc_load_val !== 32'h0 || pc_q !== 32'h0) begin
                failures++;
                $display("FAIL gnt_hold k=%0d got req=%b load=%b val=%h pc=%h exp req=1 load=1 val=0 pc=0",
                         k, imem_req, pc_load, pc_load_val, pc_q);
            end
            tick;
        end
        imem_gnt = 1'b1;
        #1;
        checks++; if (pc_load !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL gnt_issue got load=%b addr=%h exp load=0 addr=0", pc_load, imem_addr); end
        tick;
        checks++; if (pc_q !== 32'h4) begin failures++; $display("FAIL gnt_advance got=%h exp=4", pc_q); end
    endtask

    task automatic test_redirect;
        int           first;
        logic [W-1:0] fpc;
        logic [31:0]  finstr;
        instr_ready = 1'b1; imem_gnt = 1'b1; lat = 3;
        apply_reset;
        tick;
        tick;
        redirect = 1'b1; redirect_pc = 32'h103;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_req got=%b exp=0", imem_req); end
        checks++; if (pc_load !== 1'b1 || pc_load_val !== 32'h100) begin failures++; $display("FAIL redir_load got load=%b val=%h exp load=1 val=100", pc_load, pc_load_val); end
        tick;
        redirect = 1'b0;
        #1;
        checks++; if (pc_q !== 32'h100) begin failures++; $display("FAIL redir_pc got=%h exp=100", pc_q); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_valid_r1 got=%b exp=0", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_credit_req got=%b exp=0", imem_req); end
        first = -1; fpc = '0; finstr = '0;
        for (int k = 3; k < 30 && first < 0; k++) begin
            if (instr_valid) begin
                first = k; fpc = instr_pc; finstr = instr;
            end else begin
                tick;
                #1;
            end
        end
        checks++; if (first !== 8) begin failures++; $display("FAIL redir_first_cycle got=%0d exp=8", first); end
        checks++; if (fpc !== 32'h100 || finstr !== mem_word(32'h100)) begin failures++; $display("FAIL redir_first_instr got pc=%h i=%h exp pc=100 i=%h", fpc, finstr, mem_word(32'h100)); end
        tick;
        #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h104) begin failures++; $display("FAIL redir_second got v=%b pc=%h exp v=1 pc=104", instr_valid, instr_pc); end
        lat = 1;
    endtask

    task automatic test_redirect_collision;
        instr_ready = 1'b1; imem_gnt = 1'b1; lat = 1;
        apply_reset;
        tick;
        tick;
        tick;
        redirect = 1'b1; redirect_pc = 32'h200;
        #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || imem_rvalid !== 1'b1) begin failures++; $display("FAIL coll_setup got v=%b pc=%h rv=%b exp v=1 pc=4 rv=1", instr_valid, instr_pc, imem_rvalid); end
        checks++; if (imem_req !== 1'b0 || pc_load_val !== 32'h200) begin failures++; $display("FAIL coll_redir got req=%b val=%h exp req=0 val=200", imem_req, pc_load_val); end
        tick;
        redirect = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL coll_flush got=%b exp=0", instr_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL coll_req got req=%b addr=%h exp req=1 addr=200", imem_req, imem_addr); end
        tick;
        #1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL coll_no_dup got=%b exp=0", instr_valid); end
        tick;
        #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== mem_word(32'h200)) begin failures++; $display("FAIL coll_target got v=%b pc=%h i=%h exp v=1 pc=200", instr_valid, instr_pc, instr); end
        tick;
        #1;
        checks++; if (instr_pc !== 32'h204) begin failures++; $display("FAIL coll_next got=%h exp=204", instr_pc); end
    endtask

    task automatic test_reset_midstream;
        instr_ready = 1'b0; imem_gnt = 1'b1; lat = 1;
        apply_reset;
        for (int k = 0; k < 5; k++) tick;
        #1;
        checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL mid_full got v=%b req=%b exp v=1 req=0", instr_valid, imem_req); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL mid_rst got v=%b req=%b exp v=0 req=0", instr_valid, imem_req); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0 || pc_load !== 1'b1) begin failures++; $display("FAIL mid_rst_out got i=%h pc=%h load=%b exp 0 0 1", instr, instr_pc, pc_load); end
        tick;
        tick;
        rst_n = 1'b1;
        instr_ready = 1'b1;
        tick;
    endtask

    initial begin
        test_reset;
        test_stream;
        test_decode_stall;
        test_gnt_stall;
        test_redirect;
        test_redirect_collision;
        test_reset_midstream;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
